// File: rtl/nco_multi.sv
// Multi-channel NCO: CH phase accumulators sharing one time-multiplexed waveform
// table, with per-channel wrap counting over a fixed gate window.
module nco_multi #(
  parameter int unsigned CH       = 4,
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned DELTA_W  = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned FREQ_W   = 20,
  parameter int unsigned GATE_CYC = 1000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [CH-1:0]                          preload,
  input  logic [CH*PHASE_W-1:0]                  pl_data,
  input  logic [CH-1:0]                          up_dn,
  input  logic [CH*DELTA_W-1:0]                  delta,
  input  logic                                   csb0,
  input  logic                                   web0,
  input  logic [DATA_W/8-1:0]                    wmask0,
  input  logic [ADDR_W-1:0]                      addr0,
  input  logic [DATA_W-1:0]                      din0,
  input  logic [(CH > 1 ? $clog2(CH) : 1)-1:0]   freq_sel,
  output logic [CH*DATA_W-1:0]                   qout,
  output logic [FREQ_W-1:0]                      freq_out,
  output logic                                   freq_valid
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned SEL_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned GATE_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

  logic [DATA_W-1:0]                mem [DEPTH];
  logic [CH-1:0][PHASE_W-1:0]       phase;
  logic [CH-1:0][PHASE_W-1:0]       phase_nxt;
  logic [CH-1:0][PHASE_W-1:0]       d_ext;
  logic [CH-1:0][PHASE_W:0]         sum;
  logic [CH-1:0][PHASE_W:0]         diff;
  logic [CH-1:0]                    wrap_c;
  logic [CH-1:0][DATA_W-1:0]        qout_r;
  logic [CH-1:0][FREQ_W-1:0]        wcnt;
  logic [CH-1:0][FREQ_W-1:0]        wcnt_inc;
  logic [CH-1:0][FREQ_W-1:0]        flat;
  logic [SEL_W-1:0]                 slot;
  logic [GATE_W-1:0]                gate;
  logic [ADDR_W-1:0]                rd_addr;
  logic                             wr_c;
  logic                             gate_end_c;
  logic                             slot_last_c;

  assign wr_c        = !csb0 && !web0;
  assign gate_end_c  = (gate == GATE_W'(GATE_CYC - 1));
  assign slot_last_c = (slot == SEL_W'(CH - 1));
  assign rd_addr     = phase[slot][PHASE_W-1 -: ADDR_W];
  assign qout        = qout_r;

  // Next phase and wrap (carry on add, borrow on subtract) per channel
  always_comb begin
    phase_nxt = phase;
    d_ext     = '0;
    sum       = '0;
    diff      = '0;
    wrap_c    = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      d_ext[c] = PHASE_W'(delta[c*DELTA_W +: DELTA_W]);
      sum[c]   = {1'b0, phase[c]} + {1'b0, d_ext[c]};
      diff[c]  = {1'b0, phase[c]} - {1'b0, d_ext[c]};
      if (preload[c]) begin
        phase_nxt[c] = pl_data[c*PHASE_W +: PHASE_W];
      end else if (enable) begin
        if (up_dn[c]) begin
          phase_nxt[c] = sum[c][PHASE_W-1:0];
          wrap_c[c]    = sum[c][PHASE_W];
        end else begin
          phase_nxt[c] = diff[c][PHASE_W-1:0];
          wrap_c[c]    = diff[c][PHASE_W];
        end
      end
    end
  end

  // Saturating wrap-count increment
  always_comb begin
    wcnt_inc = wcnt;
    for (int unsigned c = 0; c < CH; c++) begin
      if (wrap_c[c] && (wcnt[c] != '1)) begin
        wcnt_inc[c] = wcnt[c] + FREQ_W'(1);
      end
    end
  end

  always_comb begin
    freq_out = '0;
    if (32'(freq_sel) < CH) begin
      freq_out = flat[freq_sel];
    end
  end

  // Table storage deliberately has no reset so contents survive it
  always_ff @(posedge clk) begin
    if (wr_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= '0;
      qout_r     <= '0;
      slot       <= '0;
      gate       <= '0;
      wcnt       <= '0;
      flat       <= '0;
      freq_valid <= 1'b0;
    end else begin
      phase <= phase_nxt;
      // Writes own the single table port; reads and the slot pointer stall
      if (!wr_c) begin
        qout_r[slot] <= mem[rd_addr];
        slot         <= slot_last_c ? '0 : slot + SEL_W'(1);
      end
      gate       <= gate_end_c ? '0 : gate + GATE_W'(1);
      freq_valid <= gate_end_c;
      if (gate_end_c) begin
        flat <= wcnt_inc;
        wcnt <= '0;
      end else begin
        wcnt <= wcnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_nco_multi.sv
// Scoreboard bench for nco_multi: a behavioural model predicts each cycle's
// outputs into queues; a monitor pops and compares after every clock edge.
`timescale 1ns/1ps
module tb_nco_multi;

  localparam int CH = 4, PHASE_W = 16, DELTA_W = 16, ADDR_W = 8;
  localparam int DATA_W = 32, FREQ_W = 20, GATE_CYC = 1000;

  logic                   clk;
  logic                   reset;
  logic                   enable;
  logic [CH-1:0]          preload;
  logic [CH*PHASE_W-1:0]  pl_data;
  logic [CH-1:0]          up_dn;
  logic [CH*DELTA_W-1:0]  delta;
  logic                   csb0, web0;
  logic [DATA_W/8-1:0]    wmask0;
  logic [ADDR_W-1:0]      addr0;
  logic [DATA_W-1:0]      din0;
  logic [1:0]             freq_sel;
  logic [CH*DATA_W-1:0]   qout;
  logic [FREQ_W-1:0]      freq_out;
  logic                   freq_valid;

  nco_multi #(
    .CH(CH), .PHASE_W(PHASE_W), .DELTA_W(DELTA_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .FREQ_W(FREQ_W), .GATE_CYC(GATE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .preload(preload),
    .pl_data(pl_data), .up_dn(up_dn), .delta(delta), .csb0(csb0),
    .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .freq_sel(freq_sel), .qout(qout), .freq_out(freq_out),
    .freq_valid(freq_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [CH*DATA_W-1:0] q;
    logic                 fv;
    logic [CH*FREQ_W-1:0] lat;
  } exp_t;

  exp_t                 exp_q[$];
  logic [CH*FREQ_W-1:0] freq_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state
  int          ph[CH];
  int          cnt[CH];
  int          latm[CH];
  int          slot_m;
  int          gate_m;
  logic [31:0] tbl[256];
  logic [31:0] qm[CH];
  bit          fvm;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      ph[c] = 0; cnt[c] = 0; latm[c] = 0; qm[c] = '0;
    end
    slot_m = 0; gate_m = 0; fvm = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    exp_t e;
    logic [CH*FREQ_W-1:0] lv;
    int s, d, a;
    bit wr, wrap;
    if (!reset) begin
      model_clear();
    end else begin
      wr = !csb0 && !web0;
      if (!wr) begin
        a = ph[slot_m] / (1 << (PHASE_W - ADDR_W));
        qm[slot_m] = tbl[a];
        slot_m = (slot_m + 1) % CH;
      end else begin
        for (int b = 0; b < DATA_W/8; b++)
          if (wmask0[b]) tbl[addr0][b*8 +: 8] = din0[b*8 +: 8];
      end
      for (int c = 0; c < CH; c++) begin
        d = int'(delta[c*DELTA_W +: DELTA_W]);
        wrap = 0;
        if (preload[c]) begin
          ph[c] = int'(pl_data[c*PHASE_W +: PHASE_W]);
        end else if (enable) begin
          s = up_dn[c] ? ph[c] + d : ph[c] - d;
          wrap = (s >= 65536) || (s < 0);
          ph[c] = (s + 65536) % 65536;
        end
        if (wrap && cnt[c] < (1 << FREQ_W) - 1) cnt[c]++;
      end
      if (gate_m == GATE_CYC - 1) begin
        for (int c = 0; c < CH; c++) begin
          latm[c] = cnt[c];
          cnt[c] = 0;
          lv[c*FREQ_W +: FREQ_W] = FREQ_W'(latm[c]);
        end
        freq_q.push_back(lv);
        fvm = 1;
        gate_m = 0;
      end else begin
        fvm = 0;
        gate_m++;
      end
    end
    for (int c = 0; c < CH; c++) begin
      e.q[c*DATA_W +: DATA_W]   = qm[c];
      e.lat[c*FREQ_W +: FREQ_W] = FREQ_W'(latm[c]);
    end
    e.fv = fvm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  // Monitor: compare every edge's outputs against the oldest prediction
  initial begin
    exp_t e;
    logic [CH*FREQ_W-1:0] l;
    int mcyc = 0;
    freq_sel = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("qout", qout, e.q);
        check("freq_valid", freq_valid, e.fv);
        mcyc++;
        freq_sel = 2'(mcyc % CH);
        #1;
        check("freq_out", freq_out, e.lat[int'(freq_sel)*FREQ_W +: FREQ_W]);
      end
      if (freq_valid) begin
        if (freq_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL freq_valid_unexpected: got 1 expected no pulse (t=%0t)", $time);
        end else begin
          l = freq_q.pop_front();
          for (int i = 0; i < CH; i++) begin
            freq_sel = 2'(i);
            #1;
            check("freq_latch", freq_out, l[i*FREQ_W +: FREQ_W]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = '0;
    model_clear();
    reset = 1'b0; enable = 1'b0; preload = '0; pl_data = '0; up_dn = '1;
    delta = '0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '1; addr0 = '0; din0 = '0;
    repeat (3) step();
    reset = 1'b1;

    // Table load: table[i] = i
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF;
    for (int i = 0; i < 256; i++) begin
      addr0 = 8'(i); din0 = 32'(i);
      step();
    end
    csb0 = 1'b1; web0 = 1'b1;

    // Ch0 sweep through the whole table
    up_dn = '1; delta = '0; delta[15:0] = 16'h0100; enable = 1'b1;
    repeat (300) step();

    // Byte-masked write, observed through ch2 parked at phase 0x0500
    enable = 1'b0; csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd5;
    din0 = 32'hAABBCCDD; wmask0 = 4'hF; step();
    din0 = 32'h11223344; wmask0 = 4'b0101; step();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'hF;
    delta = '0; preload = 4'b0100; pl_data[2*PHASE_W +: PHASE_W] = 16'h0500; step();
    preload = '0;
    repeat (8) step();
    check("mask_word", qout[2*DATA_W +: DATA_W], 32'hAA22CC44);

    // Frequency windows
    preload = 4'b1111; pl_data = '0; step();
    preload = '0;
    delta = {16'h0000, 16'h0800, 16'h2000, 16'h4000}; up_dn = '1; enable = 1'b1;
    repeat (2100) step();

    // Down count from 0 with delta 1 borrows to 0xFFFF
    enable = 1'b0; up_dn = 4'b1101; delta[DELTA_W +: DELTA_W] = 16'd1;
    preload = 4'b0010; pl_data[PHASE_W +: PHASE_W] = '0; step();
    preload = '0; enable = 1'b1; step();
    enable = 1'b0;
    repeat (5) step();
    check("down_wrap_q", qout[DATA_W +: DATA_W], 32'd255);

    // Preload beats enable on the same edge
    preload = 4'b0010; pl_data[PHASE_W +: PHASE_W] = 16'h3000; enable = 1'b1;
    delta[DELTA_W +: DELTA_W] = 16'h0100; step();
    preload = '0; enable = 1'b0;
    repeat (5) step();
    check("preload_wins", qout[DATA_W +: DATA_W], 32'h30);

    // Sustained writes freeze reads while phases keep moving
    enable = 1'b1; up_dn = '1; csb0 = 1'b0; web0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      addr0 = 8'($urandom); din0 = $urandom; wmask0 = 4'($urandom);
      step();
    end
    csb0 = 1'b1; web0 = 1'b1;
    repeat (20) step();

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      enable  = ($urandom % 4) != 0;
      preload = (($urandom % 16) == 0) ? 4'($urandom) : 4'h0;
      pl_data = {$urandom, $urandom};
      up_dn   = 4'($urandom);
      if (($urandom % 64) == 0) delta = {$urandom, $urandom};
      csb0    = ($urandom % 8) != 0;
      web0    = ($urandom % 2) != 0;
      addr0   = 8'($urandom); din0 = $urandom; wmask0 = 4'($urandom);
      step();
    end

    // Async reset halfway through a window
    csb0 = 1'b1; web0 = 1'b1; preload = '0; enable = 1'b1;
    delta = {16'h1000, 16'h0800, 16'h2000, 16'h4000}; up_dn = 4'b1011;
    for (int i = 0; i < 1100 && gate_m != 500; i++) step();
    model_step();
    #3;
    reset = 1'b0;
    #1;
    check("rst_qout", qout, '0);
    check("rst_freq_out", freq_out, '0);
    check("rst_freq_valid", freq_valid, 1'b0);
    exp_q.delete();
    freq_q.delete();
    model_step();
    @(negedge clk);
    repeat (3) step();
    reset = 1'b1;
    repeat (1100) step();

    @(posedge clk);
    #8;
    check("freq_q_drained", 128'(freq_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
